// File: rtl/fp_serial_pkg.sv
// Shared types for the 8-bit float serializer: word layout, word width and FSM states.
package fp_serial_pkg;

   localparam int FP_WORD_W = 8;

   typedef struct packed {
      logic       sign;
      logic [2:0] exp;
      logic [3:0] frac;
   } fp_word_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } ser_state_e;

endpackage

// File: rtl/fp_fifo.sv
// Synchronous FIFO with occupancy count; pushes are ignored when full and pops when empty.
module fp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wrPtr_q;
   logic [PW-1:0]    rdPtr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             doPush;
   logic             doPop;

   assign full   = (count_q == CW'(DEPTH));
   assign empty  = (count_q == '0);
   assign doPush = push && !full;
   assign doPop  = pop && !empty;
   assign rdata  = mem_q[rdPtr_q];
   assign count  = count_q;

   always_comb begin
      count_d = count_q;
      case ({doPush, doPop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Depth is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + PW'(1);
         if (doPop)  rdPtr_q <= rdPtr_q + PW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= wdata;
   end

endmodule

// File: rtl/fp_serializer.sv
// Buffers {s,e,f} float words and sends them as start/8 data (MSB first)/stop frames on tx.
// Define FP_SERIALIZER_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module fp_serializer
   import fp_serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        s,
   input  logic [2:0]                  e,
   input  logic [3:0]                  f,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam logic [7:0] LAST_CLK = 8'(CLKS_PER_BIT - 1);

   fp_word_t               inWord;
   logic [FP_WORD_W-1:0]   headWord;
   logic                   fifoFull;
   logic                   fifoEmpty;
   logic                   pushReq;
   logic                   popReq;
   logic                   bitEnd;

   ser_state_e             state_q;
   logic [FP_WORD_W-1:0]   word_q;
   logic [2:0]             bitIdx_q;
   logic [7:0]             cnt_q;
   logic                   tx_q;

   assign inWord   = '{sign: s, exp: e, frac: f};
   assign in_ready = !fifoFull && !rst;
   assign pushReq  = in_valid && in_ready;
   assign bitEnd   = (cnt_q == LAST_CLK);
   assign tx       = tx_q;
   assign busy     = (state_q != IDLE);

   // A word leaves the FIFO when idle, or on the last stop cycle so frames run back to back.
   always_comb begin
      popReq = 1'b0;
      if (!fifoEmpty) begin
         if (state_q == IDLE)             popReq = 1'b1;
         if (state_q == STOP && bitEnd)   popReq = 1'b1;
      end
   end

   fp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FP_WORD_W)
   ) uFifo (
      .clk   (clk),
      .rst   (rst),
      .push  (pushReq),
      .pop   (popReq),
      .wdata (inWord),
      .rdata (headWord),
      .count (fifo_count),
      .full  (fifoFull),
      .empty (fifoEmpty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         word_q   <= '0;
         bitIdx_q <= '0;
         cnt_q    <= '0;
         tx_q     <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               tx_q <= 1'b1;
               if (popReq) begin
                  word_q  <= headWord;
                  cnt_q   <= '0;
                  tx_q    <= 1'b0;
                  state_q <= START;
               end
            end
            START: begin
               if (bitEnd) begin
                  cnt_q    <= '0;
                  bitIdx_q <= '0;
                  tx_q     <= word_q[FP_WORD_W-1];
                  state_q  <= DATA;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            DATA: begin
               if (bitEnd) begin
                  cnt_q <= '0;
                  if (bitIdx_q == 3'd7) begin
                     bitIdx_q <= '0;
`ifdef FP_SERIALIZER_PARITY_EN
                     tx_q    <= ^word_q;
                     state_q <= PARITY;
`else
                     tx_q    <= 1'b1;
                     state_q <= STOP;
`endif
                  end else begin
                     // tx already shows bit (7 - bitIdx); the next one is one position lower.
                     bitIdx_q <= bitIdx_q + 3'd1;
                     tx_q     <= word_q[3'd6 - bitIdx_q];
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
`ifdef FP_SERIALIZER_PARITY_EN
            PARITY: begin
               if (bitEnd) begin
                  cnt_q   <= '0;
                  tx_q    <= 1'b1;
                  state_q <= STOP;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
`endif
            STOP: begin
               if (bitEnd) begin
                  cnt_q <= '0;
                  if (popReq) begin
                     word_q  <= headWord;
                     tx_q    <= 1'b0;
                     state_q <= START;
                  end else begin
                     tx_q    <= 1'b1;
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: begin
               cnt_q   <= '0;
               tx_q    <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_serializer.sv
// Self-checking bench for fp_serializer: frame-level model, independent line receiver and literal frame patterns.
module tb_fp_serializer;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef FP_SERIALIZER_PARITY_EN
   localparam int          NSLOT    = 11;
   localparam logic [10:0] PAT_DC   = 11'b01101110011;
   localparam logic [10:0] PAT_00   = 11'b00000000001;
   localparam int          BUSY_LIT = 44;
`else
   localparam int          NSLOT    = 10;
   localparam logic [10:0] PAT_DC   = 11'b00110111001;
   localparam logic [10:0] PAT_00   = 11'b00000000001;
   localparam int          BUSY_LIT = 40;
`endif
   localparam int FRAME = NSLOT * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic       s;
   logic [2:0] e;
   logic [3:0] f;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_count;

   int checks   = 0;
   int failures = 0;

   fp_serializer #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .s          (s),
      .e          (e),
      .f          (f),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 30)
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Line level of a frame slot: start 0, data MSB first, optional even parity, stop 1.
   function automatic logic expTx(input logic [7:0] w, input int t);
      int slot;
      slot = t / CPB;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return w[8 - slot];
`ifdef FP_SERIALIZER_PARITY_EN
      if (slot == 9) return ^w;
`endif
      return 1'b1;
   endfunction

   // Frame-level model: queue of accepted words plus position inside the current frame.
   logic [7:0] mq[$];
   bit         mActive = 0;
   bit         mValid  = 0;
   bit         mAcc;
   int         mT      = 0;
   logic [7:0] mWord   = '0;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         mActive = 0;
         mT      = 0;
         mValid  = 1;
      end else if (mValid) begin
         mAcc = in_valid && (mq.size() < DEPTH);
         if (mActive) begin
            if (mT == FRAME - 1) begin
               if (mq.size() > 0) begin
                  mWord = mq.pop_front();
                  mT    = 0;
               end else begin
                  mActive = 0;
               end
            end else begin
               mT++;
            end
         end else if (mq.size() > 0) begin
            mWord   = mq.pop_front();
            mActive = 1;
            mT      = 0;
         end
         if (mAcc) mq.push_back({s, e, f});
      end
   end

   always @(negedge clk) begin
      if (mValid) begin
         checkOutput("model_tx", 32'(tx), 32'(mActive ? expTx(mWord, mT) : 1'b1));
         checkOutput("model_busy", 32'(busy), 32'(mActive));
         checkOutput("model_count", 32'(fifo_count), 32'(mq.size()));
         checkOutput("model_ready", 32'(in_ready), 32'((mq.size() < DEPTH) && !rst));
      end
   end

   // Independent receiver decoding tx into words for the end-of-run scoreboard.
   bit         rxActive = 0;
   int         rxT      = 0;
   logic [7:0] rxWord   = '0;
   logic [7:0] rxQ[$];

   always @(negedge clk) begin
      if (rst) begin
         rxActive = 0;
      end else if (!rxActive) begin
         if (tx === 1'b0) begin
            rxActive = 1;
            rxT      = 0;
         end
      end else begin
         rxT++;
         if ((rxT % CPB == 0) && (rxT / CPB >= 1) && (rxT / CPB <= 8))
            rxWord[8 - rxT / CPB] = tx;
`ifdef FP_SERIALIZER_PARITY_EN
         if (rxT == 9 * CPB) checkOutput("rx_parity", 32'(tx), 32'(^rxWord));
`endif
         if (rxT == FRAME - CPB) begin
            checkOutput("rx_stop", 32'(tx), 32'd1);
            rxQ.push_back(rxWord);
         end
         if (rxT == FRAME - 1) rxActive = 0;
      end
   end

   int busyRun = 0;
   int lastRun = 0;

   always @(negedge clk) begin
      if (busy === 1'b1) begin
         busyRun++;
      end else begin
         if (busyRun > 0) lastRun = busyRun;
         busyRun = 0;
      end
   end

   logic [7:0] expWords[$];
   int         accepted  = 0;
   int         lastTries = 0;

   // Offers one word and keeps in_valid high until an edge accepts it.
   task automatic applyStimulus(input logic [7:0] w);
      bit ok;
      int tries;
      ok    = 0;
      tries = 0;
      in_valid  = 1'b1;
      {s, e, f} = w;
      do begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         tries++;
      end while (!ok && tries < 500);
      lastTries = tries;
      if (!ok) begin
         checkOutput("push_timeout", 32'd0, 32'd1);
      end else begin
         expWords.push_back(w);
         accepted++;
      end
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      in_valid = 1'b0;
      while ((busy !== 1'b0 || fifo_count !== 3'd0) && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("idle_timeout", 32'(n < 3000), 32'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic frameLiteral(input string name, input logic [7:0] w, input logic [10:0] pat);
      applyStimulus(w);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      for (int k = 0; k < NSLOT; k++) begin
         checkOutput(name, 32'(tx), 32'(pat[NSLOT - 1 - k]));
         repeat (CPB) @(posedge clk);
         #1;
      end
      checkOutput("lit_busy_after_frame", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("lit_busy_len", 32'(lastRun), 32'(BUSY_LIT));
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      s = 1'b0;
      e = 3'd0;
      f = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_tx", 32'(tx), 32'd1);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_count", 32'(fifo_count), 32'd0);
      checkOutput("reset_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("ready_after_reset", 32'(in_ready), 32'd1);

      $display("[TB] single word 8'hDC");
      frameLiteral("lit_DC_slot", 8'hDC, PAT_DC);

      $display("[TB] single word 8'h00");
      frameLiteral("lit_00_slot", 8'h00, PAT_00);

      $display("[TB] five words back to back");
      accepted = 0;
      applyStimulus(8'h3A);
      applyStimulus(8'hC5);
      applyStimulus(8'h81);
      applyStimulus(8'h7E);
      applyStimulus(8'h5F);
      in_valid = 1'b0;
      checkOutput("b2b_accepted", 32'(accepted), 32'd5);
      checkOutput("b2b_full_count", 32'(fifo_count), 32'd4);
      checkOutput("b2b_full_ready", 32'(in_ready), 32'd0);
      waitIdle();
      checkOutput("b2b_busy_len", 32'(lastRun), 32'(5 * BUSY_LIT));

      $display("[TB] hold in_valid against a full FIFO");
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      applyStimulus(8'h44);
      applyStimulus(8'h55);
      applyStimulus(8'h66);
      checkOutput("hold_wait_edges", 32'(lastTries), 32'(BUSY_LIT - 2));
      waitIdle();

      $display("[TB] reset during data bit 3");
      applyStimulus(8'hA5);
      applyStimulus(8'h96);
      applyStimulus(8'h0F);
      in_valid = 1'b0;
      checkOutput("abort_buffered", 32'(fifo_count), 32'd2);
      repeat (15) @(posedge clk);
      #1;
      checkOutput("abort_bit3_level", 32'(tx), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abort_tx", 32'(tx), 32'd1);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_count", 32'(fifo_count), 32'd0);
      rst = 1'b0;
      repeat (3) void'(expWords.pop_back());
      applyStimulus(8'h3C);
      waitIdle();

      checkOutput("rx_word_count", 32'(rxQ.size()), 32'(expWords.size()));
      for (int i = 0; i < expWords.size() && i < rxQ.size(); i++)
         checkOutput("rx_word", 32'(rxQ[i]), 32'(expWords[i]));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
